// File: rtl/axis_upsizer_pkg.sv
// axis_upsizer_pkg: shared sizing helpers and types for the AXIS width up-converter.
package axis_upsizer_pkg;

  // Widest lane index needed for the largest supported ratio (16 lanes).
  localparam int MAX_LANE_W = 4;

  // Lane index at its widest; narrower counters are zero-extended into it for compares.
  typedef logic [MAX_LANE_W-1:0] lane_idx_t;

  // Bits needed to address RATIO lanes; never less than one bit.
  function automatic int lane_w(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Byte-strobe count for a data bus of the given bit width.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// axis_upsizer_if: one AXI-Stream channel (valid/ready, data, byte strobes, last).
interface axis_upsizer_if #(
  parameter int DW = 32
) ();
  logic            tvalid;
  logic            tready;
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tstrb;
  logic            tlast;

  modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_upsizer_lane_ctrl.sv
// axis_upsizer_lane_ctrl: next-lane counter plus word-completion detect.
// Optional macro AXIS_UPSIZER_TLAST_EN lets an accepted tlast beat flush early.
module axis_upsizer_lane_ctrl
  import axis_upsizer_pkg::*;
#(
  parameter int RATIO = 4,
  localparam int LW = lane_w(RATIO)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_accept,
  input  logic          i_last,
  output logic [LW-1:0] o_lane,
  output logic          o_complete
);

  localparam lane_idx_t C_LAST_LANE = lane_idx_t'(RATIO - 1);

  logic [LW-1:0] r_lane;
  logic          w_full;
  logic          w_flush;

  assign w_full = (lane_idx_t'(r_lane) == C_LAST_LANE);

`ifdef AXIS_UPSIZER_TLAST_EN
  assign w_flush = i_last;
`else
  // tlast has no effect on word boundaries in this build.
  logic w_unused_last;
  assign w_unused_last = i_last;
  assign w_flush       = 1'b0;
`endif

  assign o_complete = i_accept & (w_full | w_flush);
  assign o_lane     = r_lane;

  // Advance one lane per accepted beat; wrap to lane 0 whenever a word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else if (o_complete) begin
      r_lane <= '0;
    end else if (i_accept) begin
      r_lane <= r_lane + 1'b1;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow AXIS beats into one wide beat, lane 0 in the LSBs.
// Optional macro AXIS_UPSIZER_TLAST_EN: tlast completes a partial word early
// (unfilled lanes zero) and marks it with m00 tlast.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int RATIO                  = 4,
  parameter int C_M00_AXIS_TDATA_WIDTH = C_S00_AXIS_TDATA_WIDTH * RATIO
) (
  input  logic                      axis_aclk,
  input  logic                      axis_aresetn,
  axis_upsizer_if.slave             s00_axis,
  axis_upsizer_if.master            m00_axis,
  output logic [lane_w(RATIO)-1:0]  lane
);

  localparam int SW  = C_S00_AXIS_TDATA_WIDTH;
  localparam int SSW = strb_w(SW);
  localparam int MW  = C_M00_AXIS_TDATA_WIDTH;
  localparam int MSW = strb_w(MW);
  localparam int LW  = lane_w(RATIO);

  logic [MW-1:0]  r_asm_data;
  logic [MSW-1:0] r_asm_strb;
  logic           r_m_valid;
  logic [MW-1:0]  r_m_data;
  logic [MSW-1:0] r_m_strb;
  logic           r_m_last;

  logic           w_ready;
  logic           w_accept;
  logic           w_complete;
  logic           w_last_in;
  logic [LW-1:0]  w_lane;
  logic [MW-1:0]  w_fill_data;
  logic [MSW-1:0] w_fill_strb;

  // A new narrow beat can enter whenever the output slot is empty or draining.
  assign w_ready  = ~r_m_valid | m00_axis.tready;
  assign w_accept = s00_axis.tvalid & w_ready;

`ifdef AXIS_UPSIZER_TLAST_EN
  assign w_last_in = s00_axis.tlast;
`else
  assign w_last_in = 1'b0;
`endif

  axis_upsizer_lane_ctrl #(
    .RATIO (RATIO)
  ) u_lane_ctrl (
    .clk        (axis_aclk),
    .rst_n      (axis_aresetn),
    .i_accept   (w_accept),
    .i_last     (s00_axis.tlast),
    .o_lane     (w_lane),
    .o_complete (w_complete)
  );

  // Assembly word with the current beat merged into its lane; lanes above the
  // current one are still zero because the assembly clears on every completion.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    localparam logic [LW-1:0] C_IDX = LW'(gi);
    logic w_hit;
    assign w_hit = w_accept && (w_lane == C_IDX);
    assign w_fill_data[gi*SW  +: SW]  = w_hit ? s00_axis.tdata : r_asm_data[gi*SW  +: SW];
    assign w_fill_strb[gi*SSW +: SSW] = w_hit ? s00_axis.tstrb : r_asm_strb[gi*SSW +: SSW];
  end

  // Assembly register: accumulate accepted beats, clear once the word moves to the output.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_asm_data <= '0;
      r_asm_strb <= '0;
    end else if (w_complete) begin
      r_asm_data <= '0;
      r_asm_strb <= '0;
    end else if (w_accept) begin
      r_asm_data <= w_fill_data;
      r_asm_strb <= w_fill_strb;
    end
  end

  // Output holding register: load on completion (even while draining), else drop valid on transfer.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_strb  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_complete) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_fill_data;
      r_m_strb  <= w_fill_strb;
      r_m_last  <= w_last_in;
    end else if (r_m_valid && m00_axis.tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign s00_axis.tready = w_ready;
  assign m00_axis.tvalid = r_m_valid;
  assign m00_axis.tdata  = r_m_data;
  assign m00_axis.tstrb  = r_m_strb;
  assign m00_axis.tlast  = r_m_last;
  assign lane            = w_lane;

endmodule
